// File: rtl/ram_inject_multi.sv
// rtl/ram_inject_multi.sv - multi-channel PSRAM read-burst data injector.
// Optional INJECT_ONESHOT_EN: a channel disarms itself on its own hit.
module ram_inject_multi #(
    parameter int          NUM_CH       = 4,
    parameter int          PATCH_WORDS  = 4,
    parameter logic [15:0] CFG_BASE     = 16'h0100,
    parameter int          READ_LATENCY = 4
) (
    input  logic        mclk,
    input  logic        reset,
    input  logic [15:0] config_addr,
    input  logic [15:0] config_data,
    input  logic        config_strobe,
    input  logic [22:0] filter_a,
    input  logic        filter_read,
    input  logic        filter_write,
    input  logic        filter_addr_latch,
    input  logic        filter_strobe,
    input  logic        ram_enable,
    input  logic        ram_oe_n,
    output logic        ram_ce1_out,
    output logic [15:0] ram_d_out,
    output logic        ram_d_oe,
    output logic [2:0]  hit_ch,
    output logic        hit_strobe
);
    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_DRIVE, S_HOLD} state_t;

    state_t                                 state_q, state_d;
    logic [NUM_CH-1:0]                      ch_en_q, ch_en_d;
    logic [NUM_CH-1:0][22:0]                ch_addr_q, ch_addr_d;
    logic [NUM_CH-1:0][PATCH_WORDS-1:0][15:0] ch_data_q, ch_data_d;
    logic [7:0]                             burst_cycle_q, burst_cycle_d;
    logic [2:0]                             arm_ch_q, arm_ch_d;
    logic [2:0]                             hit_ch_q, hit_ch_d;
    logic                                   ce1_q, ce1_d;
    logic                                   hit_strobe_q, hit_strobe_d;
    logic [15:0]                            d_out_q, d_out_d;

    logic        match_any;
    logic [2:0]  match_ch;
    int          drive_k;
    logic [15:0] drive_word;
    logic [15:0] cfg_off;
    logic        cfg_hit;

    assign cfg_off = config_addr - CFG_BASE;
    assign cfg_hit = config_strobe && (config_addr >= CFG_BASE) && (cfg_off < 16'(8 * NUM_CH));

    // Descending scan so the lowest-numbered matching channel is the one left standing.
    always_comb begin
        match_any = 1'b0;
        match_ch  = 3'd0;
        for (int c = NUM_CH - 1; c >= 0; c--) begin
            if (ch_en_q[c] && (ch_addr_q[c] == filter_a)) begin
                match_any = 1'b1;
                match_ch  = 3'(c);
            end
        end
    end

    // k counts words from the first valid read cycle; early cycles preload word 0.
    always_comb begin
        drive_k    = int'(burst_cycle_q) - (READ_LATENCY - 1);
        drive_word = 16'hFFFF;
        for (int c = 0; c < NUM_CH; c++) begin
            for (int w = 0; w < PATCH_WORDS; w++) begin
                if ((arm_ch_q == 3'(c)) && (((w == 0) && (drive_k < 0)) || (drive_k == w))) begin
                    drive_word = ch_data_q[c][w];
                end
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        ch_en_d       = ch_en_q;
        ch_addr_d     = ch_addr_q;
        ch_data_d     = ch_data_q;
        burst_cycle_d = burst_cycle_q;
        arm_ch_d      = arm_ch_q;
        hit_ch_d      = hit_ch_q;
        ce1_d         = ce1_q;
        hit_strobe_d  = 1'b0;
        d_out_d       = d_out_q;

        if (filter_strobe && filter_addr_latch) begin
            burst_cycle_d = 8'd0;
        end else if (filter_strobe && (filter_read || filter_write) && (burst_cycle_q != 8'hFF)) begin
            burst_cycle_d = burst_cycle_q + 8'd1;
        end

        if (!ram_enable) begin
            state_d = S_IDLE;
            ce1_d   = 1'b0;
        end else if (filter_strobe && filter_addr_latch) begin
            if (match_any) begin
                state_d  = S_ARMED;
                arm_ch_d = match_ch;
            end else begin
                state_d = S_IDLE;
                ce1_d   = 1'b0;
            end
        end else if (filter_strobe && filter_write && (state_q == S_ARMED)) begin
            state_d = S_IDLE;
            ce1_d   = 1'b0;
        end else if (filter_strobe && filter_read && (state_q != S_IDLE)) begin
            if (state_q == S_HOLD) begin
                d_out_d = 16'hFFFF;
            end else begin
                d_out_d = drive_word;
                state_d = (drive_k >= PATCH_WORDS - 1) ? S_HOLD : S_DRIVE;
                if (state_q == S_ARMED) begin
                    ce1_d        = 1'b1;
                    hit_strobe_d = 1'b1;
                    hit_ch_d     = arm_ch_q;
`ifdef INJECT_ONESHOT_EN
                    for (int c = 0; c < NUM_CH; c++) begin
                        if (arm_ch_q == 3'(c)) ch_en_d[c] = 1'b0;
                    end
`endif
                end
            end
        end

        // Applied after the one-shot clear so a same-cycle enable write wins.
        if (cfg_hit) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (cfg_off[5:3] == 3'(c)) begin
                    if (cfg_off[2:0] == 3'd0) ch_addr_d[c][15:0] = config_data;
                    if (cfg_off[2:0] == 3'd1) begin
                        ch_en_d[c]           = config_data[15];
                        ch_addr_d[c][22:16]  = config_data[6:0];
                    end
                    for (int w = 0; w < PATCH_WORDS; w++) begin
                        if (cfg_off[2:0] == 3'(w + 2)) ch_data_d[c][w] = config_data;
                    end
                end
            end
        end
    end

    always_ff @(posedge mclk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            ch_en_q       <= '0;
            ch_addr_q     <= '0;
            ch_data_q     <= '0;
            burst_cycle_q <= 8'd0;
            arm_ch_q      <= 3'd0;
            hit_ch_q      <= 3'd0;
            ce1_q         <= 1'b0;
            hit_strobe_q  <= 1'b0;
            d_out_q       <= 16'd0;
        end else begin
            state_q       <= state_d;
            ch_en_q       <= ch_en_d;
            ch_addr_q     <= ch_addr_d;
            ch_data_q     <= ch_data_d;
            burst_cycle_q <= burst_cycle_d;
            arm_ch_q      <= arm_ch_d;
            hit_ch_q      <= hit_ch_d;
            ce1_q         <= ce1_d;
            hit_strobe_q  <= hit_strobe_d;
            d_out_q       <= d_out_d;
        end
    end

    assign ram_ce1_out = ce1_q;
    assign ram_d_out   = d_out_q;
    assign ram_d_oe    = ram_enable && !ram_oe_n && ce1_q;
    assign hit_ch      = hit_ch_q;
    assign hit_strobe  = hit_strobe_q;
endmodule

// File: tb/tb_ram_inject_multi.sv
// tb/tb_ram_inject_multi.sv - directed and randomized bursts against a behavioural injector model.
module tb_ram_inject_multi;
    localparam int          NCH  = 4;
    localparam int          PW   = 4;
    localparam int          RL   = 4;
    localparam logic [15:0] BASE = 16'h0100;

    logic        mclk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] config_addr = '0, config_data = '0;
    logic        config_strobe = 1'b0;
    logic [22:0] filter_a = '0;
    logic        filter_read = 1'b0, filter_write = 1'b0, filter_addr_latch = 1'b0, filter_strobe = 1'b0;
    logic        ram_enable = 1'b0, ram_oe_n = 1'b1;
    logic        ram_ce1_out, ram_d_oe, hit_strobe;
    logic [15:0] ram_d_out;
    logic [2:0]  hit_ch;

    ram_inject_multi #(.NUM_CH(NCH), .PATCH_WORDS(PW), .CFG_BASE(BASE), .READ_LATENCY(RL)) dut (
        .mclk(mclk), .reset(reset), .config_addr(config_addr), .config_data(config_data),
        .config_strobe(config_strobe), .filter_a(filter_a), .filter_read(filter_read),
        .filter_write(filter_write), .filter_addr_latch(filter_addr_latch),
        .filter_strobe(filter_strobe), .ram_enable(ram_enable), .ram_oe_n(ram_oe_n),
        .ram_ce1_out(ram_ce1_out), .ram_d_out(ram_d_out), .ram_d_oe(ram_d_oe),
        .hit_ch(hit_ch), .hit_strobe(hit_strobe)
    );

    always #5 mclk = ~mclk;

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: channel tables plus a burst phase (0 idle, 1 armed, 2 driving, 3 holding).
    logic [22:0] m_addr [NCH];
    logic        m_en   [NCH];
    logic [15:0] m_data [NCH][PW];
    int          m_phase, m_ch, m_bc, mk, mmc, moff;
    logic        m_ce1, m_hs;
    logic [15:0] m_d;
    logic [2:0]  m_hit;

    always @(posedge mclk) begin
        m_hs = 1'b0;
        if (reset) begin
            for (int c = 0; c < NCH; c++) begin
                m_addr[c] = '0;
                m_en[c]   = 1'b0;
                for (int w = 0; w < PW; w++) m_data[c][w] = '0;
            end
            m_phase = 0; m_ch = 0; m_bc = 0; m_ce1 = 1'b0; m_d = '0; m_hit = '0;
        end else begin
            mmc = -1;
            for (int c = NCH - 1; c >= 0; c--) if (m_en[c] && m_addr[c] == filter_a) mmc = c;
            if (!ram_enable) begin
                m_phase = 0; m_ce1 = 1'b0;
            end else if (filter_strobe && filter_addr_latch) begin
                if (mmc >= 0) begin m_phase = 1; m_ch = mmc; end
                else begin m_phase = 0; m_ce1 = 1'b0; end
            end else if (filter_strobe && filter_write && m_phase == 1) begin
                m_phase = 0; m_ce1 = 1'b0;
            end else if (filter_strobe && filter_read && m_phase != 0) begin
                mk = m_bc - (RL - 1);
                if (m_phase == 3) m_d = 16'hFFFF;
                else begin
                    m_d = (mk < 0) ? m_data[m_ch][0] : (mk < PW) ? m_data[m_ch][mk] : 16'hFFFF;
                    if (m_phase == 1) begin
                        m_ce1 = 1'b1; m_hs = 1'b1; m_hit = 3'(m_ch);
`ifdef INJECT_ONESHOT_EN
                        m_en[m_ch] = 1'b0;
`endif
                    end
                    m_phase = (mk >= PW - 1) ? 3 : 2;
                end
            end
            if (filter_strobe && filter_addr_latch) m_bc = 0;
            else if (filter_strobe && (filter_read || filter_write) && m_bc < 255) m_bc++;
            if (config_strobe && config_addr >= BASE && config_addr < BASE + 16'(8 * NCH)) begin
                moff = int'(config_addr - BASE);
                if (moff % 8 == 0) m_addr[moff / 8][15:0] = config_data;
                else if (moff % 8 == 1) begin
                    m_en[moff / 8] = config_data[15];
                    m_addr[moff / 8][22:16] = config_data[6:0];
                end else if (moff % 8 < 2 + PW) m_data[moff / 8][moff % 8 - 2] = config_data;
            end
        end
    end

    always @(negedge mclk) begin
        if (cmp_en) begin
            chk("ce1", {31'd0, ram_ce1_out}, {31'd0, m_ce1});
            chk("d_out", {16'd0, ram_d_out}, {16'd0, m_d});
            chk("d_oe", {31'd0, ram_d_oe}, {31'd0, ram_enable && !ram_oe_n && m_ce1});
            chk("hit_ch", {29'd0, hit_ch}, {29'd0, m_hit});
            chk("hit_strobe", {31'd0, hit_strobe}, {31'd0, m_hs});
        end
    end

    logic [15:0] seen_d [16];
    logic        seen_ce1 [16];
    int          hits;
    logic        ce1_any, abort_ce1;

    task automatic cfg_write(input logic [15:0] a, input logic [15:0] d);
        config_addr = a; config_data = d; config_strobe = 1'b1;
        @(posedge mclk); #1;
        config_strobe = 1'b0;
    endtask

    task automatic cfg_channel(input int c, input logic [22:0] a, input bit en,
                               input logic [15:0] w0, w1, w2, w3);
        logic [15:0] cb;
        cb = BASE + 16'(8 * c);
        cfg_write(cb, a[15:0]);
        cfg_write(cb + 16'd1, {en, 8'd0, a[22:16]});
        cfg_write(cb + 16'd2, w0);
        cfg_write(cb + 16'd3, w1);
        cfg_write(cb + 16'd4, w2);
        cfg_write(cb + 16'd5, w3);
    endtask

    task automatic ram_edge(input bit l, input bit r, input bit w, input logic [22:0] a);
        filter_strobe = 1'b1; filter_addr_latch = l; filter_read = r; filter_write = w; filter_a = a;
        @(posedge mclk); #1;
        filter_strobe = 1'b0; filter_addr_latch = 1'b0; filter_read = 1'b0; filter_write = 1'b0;
        @(negedge mclk);
        if (hit_strobe) hits++;
        ce1_any = ce1_any | ram_ce1_out;
        @(posedge mclk); #1;
    endtask

    task automatic burst(input logic [22:0] a, input bit rd, input int n, input int abort_at, input bit abort_rst);
        hits = 0; ce1_any = 1'b0; abort_ce1 = 1'b0;
        ram_enable = 1'b1; ram_oe_n = !rd;
        ram_edge(1'b1, rd, !rd, a);
        for (int i = 0; i < n; i++) begin
            if (i == abort_at) begin
                if (abort_rst) reset = 1'b1; else ram_enable = 1'b0;
                @(posedge mclk); #1;
                reset = 1'b0;
                @(negedge mclk);
                abort_ce1 = ram_ce1_out;
                @(posedge mclk); #1;
                break;
            end
            ram_edge(1'b0, rd, !rd, a);
            seen_d[i] = ram_d_out;
            seen_ce1[i] = ram_ce1_out;
        end
        ram_enable = 1'b0; ram_oe_n = 1'b1;
        repeat (2) begin @(posedge mclk); #1; end
    endtask

    logic [22:0] pool [4];
    logic [22:0] ra;
    int          ab, sel;

    initial begin
        pool[0] = 23'h4394F0; pool[1] = 23'h000100; pool[2] = 23'h7FFFFF; pool[3] = 23'h012345;
        repeat (2) @(posedge mclk);
        #1;
        cmp_en = 1'b1;
        @(negedge mclk);
        chk("rst_ce1", {31'd0, ram_ce1_out}, 32'd0);
        chk("rst_d_out", {16'd0, ram_d_out}, 32'd0);
        chk("rst_hit_ch", {29'd0, hit_ch}, 32'd0);
        chk("rst_hit_strobe", {31'd0, hit_strobe}, 32'd0);
        @(posedge mclk); #1;
        reset = 1'b0;

        cfg_channel(0, 23'h4394F0, 1'b1, 16'h0078, 16'h1111, 16'h2222, 16'h3333);
        burst(23'h4394F0, 1'b1, 10, -1, 1'b0);
        chk("b1_ce1_first", {31'd0, seen_ce1[0]}, 32'd1);
        chk("b1_w3", {16'd0, seen_d[3]}, 32'h0078);
        chk("b1_w4", {16'd0, seen_d[4]}, 32'h1111);
        chk("b1_w5", {16'd0, seen_d[5]}, 32'h2222);
        chk("b1_w6", {16'd0, seen_d[6]}, 32'h3333);
        chk("b1_w7", {16'd0, seen_d[7]}, 32'hFFFF);
        chk("b1_hits", hits, 32'd1);

        cfg_channel(1, 23'h000100, 1'b1, 16'hA100, 16'hA101, 16'hA102, 16'hA103);
        cfg_channel(2, 23'h000100, 1'b1, 16'hB200, 16'hB201, 16'hB202, 16'hB203);
        burst(23'h000100, 1'b1, 8, -1, 1'b0);
        chk("prio_hits", hits, 32'd1);
        chk("prio_hit_ch", {29'd0, hit_ch}, 32'd1);
        chk("prio_w3", {16'd0, seen_d[3]}, 32'hA100);

        cfg_write(BASE + 16'd1, 16'h8043);
        burst(23'h4394F0, 1'b0, 8, -1, 1'b0);
        chk("wr_ce1_any", {31'd0, ce1_any}, 32'd0);
        chk("wr_hits", hits, 32'd0);

        cfg_write(BASE + 16'd1, 16'h8043);
        burst(23'h4394F0, 1'b1, 10, 4, 1'b0);
        chk("drop_ce1", {31'd0, abort_ce1}, 32'd0);
        burst(23'h123456, 1'b1, 6, -1, 1'b0);
        chk("drop_pass_ce1", {31'd0, ce1_any}, 32'd0);

        cfg_write(BASE + 16'd1, 16'h8043);
        burst(23'h4394F0, 1'b1, 10, 4, 1'b1);
        chk("rst_mid_ce1", {31'd0, abort_ce1}, 32'd0);
        burst(23'h123456, 1'b1, 6, -1, 1'b0);
        chk("rst_pass_ce1", {31'd0, ce1_any}, 32'd0);

        cfg_channel(0, 23'h4394F0, 1'b1, 16'h0078, 16'h1111, 16'h2222, 16'h3333);
        cfg_write(BASE + 16'(8 * NCH), 16'hDEAD);
        cfg_write(BASE + 16'd7, 16'hDEAD);
        cfg_write(BASE + 16'd6, 16'hBEEF);
        burst(23'h4394F0, 1'b1, 10, -1, 1'b0);
        chk("unmap_w3", {16'd0, seen_d[3]}, 32'h0078);
        chk("unmap_w6", {16'd0, seen_d[6]}, 32'h3333);

        cfg_write(BASE + 16'd1, 16'h8043);
        burst(23'h4394F0, 1'b1, 8, -1, 1'b0);
        chk("os_first_hits", hits, 32'd1);
        burst(23'h4394F0, 1'b1, 8, -1, 1'b0);
`ifdef INJECT_ONESHOT_EN
        chk("os_second_hits", hits, 32'd0);
        chk("os_second_ce1", {31'd0, ce1_any}, 32'd0);
`else
        chk("os_second_hits", hits, 32'd1);
        chk("os_second_ce1", {31'd0, ce1_any}, 32'd1);
`endif
        cfg_write(BASE + 16'd1, 16'h8043);
        burst(23'h4394F0, 1'b1, 8, -1, 1'b0);
        chk("os_rearm_hits", hits, 32'd1);

        for (int it = 0; it < 60; it++) begin
            sel = $urandom_range(0, 9);
            if (sel < 3)
                cfg_channel($urandom_range(0, NCH - 1), pool[$urandom_range(0, 3)], 1'($urandom_range(0, 1)),
                            16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
            else if (sel == 3)
                cfg_write(BASE + 16'($urandom_range(0, 8 * NCH + 3)), 16'($urandom));
            ra = ($urandom_range(0, 3) == 0) ? 23'($urandom) : pool[$urandom_range(0, 3)];
            ab = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 6)) : -1;
            burst(ra, 1'($urandom_range(0, 2) != 0), $urandom_range(1, 10), ab, 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        n_bad++;
        $display("FAIL timeout: simulation exceeded its time budget");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "timeout");
    end
endmodule
